stream_mux: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshaking. It supersedes the plain combinational 2:1 selector. Every input channel is a valid/ready stream. The output is a single registered stream that carries the source channel index. Selection is either manual, driven by a select port, or round-robin arbitration, chosen at run time. It sits between multiple producers and one shared consumer, such as a shared bus or FIFO write port.

---
 rtl/stream_mux.sv | 125 ++++++++++++
 tb/tb_stream_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// N-channel, W-bit registered stream multiplexer with valid/ready handshaking.
// Selection is manual (SEL) or round-robin. Define MUX_LOCK_EN to enable packet lock.
module stream_mux #(
  parameter  int unsigned W  = 8,
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_mode,
  input  logic [SW-1:0]  i_sel,
  input  logic [N*W-1:0] i_in_data,
  input  logic [N-1:0]   i_in_valid,
  input  logic [N-1:0]   i_in_last,
  output logic [N-1:0]   o_in_ready_c,
  output logic [W-1:0]   o_out_data,
  output logic           o_out_valid,
  output logic           o_out_last,
  output logic [SW-1:0]  o_out_ch,
  input  logic           i_out_ready
);

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic [SW-1:0] r_out_ch;
  logic [SW-1:0] r_last_grant;

  logic          w_free;
  logic          w_grant_vld;
  logic [SW-1:0] w_grant;
  logic          w_take;
  logic [SW-1:0] w_sel_grant;
  logic          w_sel_vld;
  logic [SW-1:0] w_rr_grant;
  logic          w_rr_vld;

`ifdef MUX_LOCK_EN
  logic          r_locked;
  logic [SW-1:0] r_lock_ch;
`endif

  assign w_free = !r_out_valid || i_out_ready;

  // Manual selection: out-of-range or idle SEL yields no grant.
  always_comb begin
    w_sel_vld   = 1'b0;
    w_sel_grant = i_sel;
    if (32'(i_sel) < N) begin
      w_sel_vld = i_in_valid[i_sel];
    end
  end

  // Round-robin: first valid channel after the last grant, with wrap-around.
  always_comb begin
    logic [SW-1:0] idx;
    idx        = '0;
    w_rr_vld   = 1'b0;
    w_rr_grant = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = SW'((32'(r_last_grant) + k) % N);
      if (!w_rr_vld && i_in_valid[idx]) begin
        w_rr_vld   = 1'b1;
        w_rr_grant = idx;
      end
    end
  end

  always_comb begin
    w_grant_vld = i_mode ? w_rr_vld   : w_sel_vld;
    w_grant     = i_mode ? w_rr_grant : w_sel_grant;
`ifdef MUX_LOCK_EN
    // A locked packet owns the output until its last beat, even while idle.
    if (r_locked) begin
      w_grant_vld = i_in_valid[r_lock_ch];
      w_grant     = r_lock_ch;
    end
`endif
  end

  assign w_take = rst_n && w_grant_vld && w_free;

  always_comb begin
    o_in_ready_c = '0;
    if (w_take) begin
      o_in_ready_c[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_ch     <= '0;
      r_last_grant <= SW'(N - 1);
    end else if (w_take) begin
      r_out_data   <= i_in_data[32'(w_grant) * W +: W];
      r_out_valid  <= 1'b1;
      r_out_last   <= i_in_last[w_grant];
      r_out_ch     <= w_grant;
      r_last_grant <= w_grant;
    end else if (i_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_take) begin
      r_locked  <= !i_in_last[w_grant];
      r_lock_ch <= w_grant;
    end
  end
`endif

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (N=4, W=8); honours MUX_LOCK_EN.
module tb_stream_mux;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;

  logic           clk;
  logic           rst_n;
  logic           i_mode;
  logic [SW-1:0]  i_sel;
  logic [N*W-1:0] i_in_data;
  logic [N-1:0]   i_in_valid;
  logic [N-1:0]   i_in_last;
  logic [N-1:0]   o_in_ready_c;
  logic [W-1:0]   o_out_data;
  logic           o_out_valid;
  logic           o_out_last;
  logic [SW-1:0]  o_out_ch;
  logic           i_out_ready;

  int n_chk = 0;
  int n_err = 0;

  stream_mux #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mode      (i_mode),
    .i_sel       (i_sel),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .i_in_last   (i_in_last),
    .o_in_ready_c(o_in_ready_c),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last),
    .o_out_ch    (o_out_ch),
    .i_out_ready (i_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] v);
    i_in_data[ch*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  int exp_seq[5];
  int beats0;
  logic [N-1:0] rdy;

  initial begin
    rst_n       = 1'b0;
    i_mode      = 1'b0;
    i_sel       = '0;
    i_in_data   = '0;
    i_in_valid  = 4'hF;
    i_in_last   = 4'hF;
    i_out_ready = 1'b1;
    #2;
    check("rst_valid", 32'(o_out_valid), 32'd0);
    check("rst_data",  32'(o_out_data),  32'd0);
    check("rst_last",  32'(o_out_last),  32'd0);
    check("rst_ch",    32'(o_out_ch),    32'd0);
    check("rst_ready", 32'(o_in_ready_c), 32'd0);
    rst_n = 1'b1;

    // Manual select of channel 2
    i_mode = 1'b0; i_sel = 2'd2; i_in_valid = 4'b0110;
    set_data(1, 8'h11); set_data(2, 8'h5A);
    #1;
    check("sel_ready", 32'(o_in_ready_c), 32'b0100);
    tick();
    check("sel_data",  32'(o_out_data),  32'h5A);
    check("sel_ch",    32'(o_out_ch),    32'd2);
    check("sel_valid", 32'(o_out_valid), 32'd1);
    i_in_valid = '0;
    tick();
    check("sel_drain", 32'(o_out_valid), 32'd0);

    // Round-robin with all channels valid
    do_reset();
    i_mode = 1'b1; i_in_valid = 4'hF; i_out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_valid", 32'(o_out_valid), 32'd1);
      check("rr_ch",    32'(o_out_ch),    32'(i % 4));
      check("rr_data",  32'(o_out_data),  32'h A0 + 32'(i % 4));
    end
    i_in_valid = '0;
    tick();

    // Back-pressure: ch1 then ch3
    do_reset();
    i_mode = 1'b1; i_in_valid = 4'b1010; i_out_ready = 1'b0;
    set_data(1, 8'h31); set_data(3, 8'h33);
    tick();
    check("bp_first_ch", 32'(o_out_ch), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(o_in_ready_c), 32'd0);
      tick();
      check("bp_ch",    32'(o_out_ch),    32'd1);
      check("bp_data",  32'(o_out_data),  32'h31);
      check("bp_valid", 32'(o_out_valid), 32'd1);
    end
    i_out_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(o_in_ready_c), 32'b1000);
    tick();
    check("bp_next_ch",   32'(o_out_ch),   32'd3);
    check("bp_next_data", 32'(o_out_data), 32'h33);
    i_in_valid = '0;
    tick();
    check("bp_idle", 32'(o_out_valid), 32'd0);

    // Manual select of an idle channel drains the pending beat
    do_reset();
    i_mode = 1'b0; i_sel = 2'd0; i_in_valid = 4'b0001; i_out_ready = 1'b0;
    set_data(0, 8'h44);
    tick();
    check("idle_pend_valid", 32'(o_out_valid), 32'd1);
    check("idle_pend_data",  32'(o_out_data),  32'h44);
    i_sel = 2'd3; i_out_ready = 1'b1;
    #1;
    check("idle_ready", 32'(o_in_ready_c), 32'd0);
    tick();
    check("idle_valid", 32'(o_out_valid), 32'd0);
    check("idle_ready2", 32'(o_in_ready_c), 32'd0);

    // Packet of three beats on ch0 with ch1 continuously valid
    do_reset();
`ifdef MUX_LOCK_EN
    exp_seq = '{0, 0, 0, 1, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    i_mode = 1'b1; i_out_ready = 1'b1; beats0 = 0;
    for (int i = 0; i < 5; i++) begin
      i_in_valid = {2'b00, 1'b1, (beats0 < 3)};
      i_in_last  = {2'b11, 1'b1, (beats0 == 2)};
      set_data(0, 8'h10 + 8'(beats0));
      set_data(1, 8'h21);
      #1;
      rdy = o_in_ready_c;
      tick();
      check("pkt_ch", 32'(o_out_ch), 32'(exp_seq[i]));
      if (rdy[0]) begin
        check("pkt_data0", 32'(o_out_data), 32'h10 + 32'(beats0));
        check("pkt_last0", 32'(o_out_last), 32'(beats0 == 2));
        beats0++;
      end
    end
    check("pkt_beats0", 32'(beats0), 32'd3);
    i_in_valid = '0; i_in_last = 4'hF;
    tick();

    // Asynchronous reset mid-stream
    do_reset();
    i_mode = 1'b1; i_in_valid = 4'hF; i_out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    tick();
    tick();
    check("mid_pre_valid", 32'(o_out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(o_out_valid), 32'd0);
    check("mid_data",  32'(o_out_data),  32'd0);
    check("mid_ready", 32'(o_in_ready_c), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("mid_first_ch",   32'(o_out_ch),   32'd0);
    check("mid_first_data", 32'(o_out_data), 32'hA0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
